// File: rtl/sramlike_pkg.sv
// Shared encodings and the byte-enable generator for the sram-like arbiter bridge.
package sramlike_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    // Byte write enables for one access; misaligned half/word accesses write nothing.
    function automatic logic [3:0] wen_gen(input logic [1:0] size,
                                           input logic [1:0] addr_lo,
                                           input logic       wr);
        logic [3:0] w;
        w = 4'b0000;
        if (wr) begin
            case (size)
                SZ_BYTE: w = 4'b0001 << addr_lo;
                SZ_HALF: w = addr_lo[0] ? 4'b0000 : (addr_lo[1] ? 4'b1100 : 4'b0011);
                default: w = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/sramlike_rr_arb.sv
// One-hot grant among eligible channels: round-robin from ptr+1, or fixed with highest index winning.
module sramlike_rr_arb
    import sramlike_pkg::*;
#(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned ARB_MODE = ARB_RR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] elig,
    input  logic            taken,
    output logic [N_CH-1:0] grant
);

    localparam int unsigned PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [PW-1:0] ptr;

    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (ARB_MODE == ARB_FIXED) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (elig[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= int'(N_CH); k++) begin
                idx = (int'(ptr) + k) % int'(N_CH);
                for (int i = 0; i < int'(N_CH); i++) begin
                    if (!found && i == idx && elig[i]) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    // Pointer remembers the last winner so the search starts just past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= PW'(N_CH - 1);
        end else if (taken) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (grant[i]) ptr <= PW'(i);
            end
        end
    end

endmodule

// File: rtl/sramlike_arb_bridge.sv
// Arbitrates N_CH sram-like masters onto one synchronous SRAM with in-order, fixed-latency responses.
// Optional per-channel stall counters (perf_stall) are built when BRIDGE_PERF_CNT_EN is defined.
module sramlike_arb_bridge
    import sramlike_pkg::*;
#(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_OUT  = 2,
    parameter int unsigned ARB_MODE = ARB_RR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      m_req,
    input  logic [N_CH-1:0]      m_wr,
    input  logic [2*N_CH-1:0]    m_size,
    input  logic [32*N_CH-1:0]   m_addr,
    input  logic [32*N_CH-1:0]   m_wdata,
    output logic [32*N_CH-1:0]   m_rdata,
    output logic [N_CH-1:0]      m_addr_ok,
    output logic [N_CH-1:0]      m_data_ok,
    output logic                 sram_en,
    output logic [3:0]           sram_wen,
    output logic [31:0]          sram_addr,
    output logic [31:0]          sram_wdata,
    input  logic [31:0]          sram_rdata
`ifdef BRIDGE_PERF_CNT_EN
    ,
    output logic [32*N_CH-1:0]   perf_stall
`endif
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    logic [N_CH-1:0]    elig;
    logic [N_CH-1:0]    grant;
    logic [N_CH-1:0]    dok_pipe [RD_LAT];
    logic [CW-1:0]      out_cnt  [N_CH];
    logic [32*N_CH-1:0] rd_hold;

    // A response retiring this cycle frees its slot, so MAX_OUT >= RD_LAT sustains one access per cycle.
    always_comb begin
        elig = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            elig[i] = !rst && m_req[i] && ((out_cnt[i] < CW'(MAX_OUT)) || m_data_ok[i]);
        end
    end

    sramlike_rr_arb #(
        .N_CH     (N_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .elig  (elig),
        .taken (|grant),
        .grant (grant)
    );

    assign m_addr_ok = grant;
    assign m_data_ok = dok_pipe[RD_LAT-1];

    always_comb begin
        sram_en    = |grant;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_wen   = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (grant[i]) begin
                sram_addr  = m_addr[i*32 +: 32];
                sram_wdata = m_wdata[i*32 +: 32];
                sram_wen   = wen_gen(m_size[i*2 +: 2], m_addr[i*32 +: 2], m_wr[i]);
            end
        end
    end

    // One-hot lane tag travels with each access; the last stage is the data_ok pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(RD_LAT); k++) dok_pipe[k] <= '0;
        end else begin
            dok_pipe[0] <= grant;
            for (int k = 1; k < int'(RD_LAT); k++) dok_pipe[k] <= dok_pipe[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_hold <= '0;
            for (int i = 0; i < int'(N_CH); i++) out_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (m_data_ok[i]) rd_hold[i*32 +: 32] <= sram_rdata;
                if (m_addr_ok[i] && !m_data_ok[i]) begin
                    out_cnt[i] <= out_cnt[i] + CW'(1);
                end else if (!m_addr_ok[i] && m_data_ok[i]) begin
                    out_cnt[i] <= out_cnt[i] - CW'(1);
                end
            end
        end
    end

    // Lane shows SRAM data in its data_ok cycle and keeps it until the next response on that lane.
    always_comb begin
        m_rdata = rd_hold;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (m_data_ok[i]) m_rdata[i*32 +: 32] = sram_rdata;
        end
    end

`ifdef BRIDGE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall <= '0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (m_req[i] && !m_addr_ok[i] && (perf_stall[i*32 +: 32] != 32'hFFFF_FFFF)) begin
                    perf_stall[i*32 +: 32] <= perf_stall[i*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sramlike_arb_bridge.sv
// Directed bench: a round-robin bridge (RD_LAT 2, MAX_OUT 2) and a fixed-priority one (RD_LAT 3, MAX_OUT 1).
module tb_sramlike_arb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req, m_wr;
    logic [3:0]  m_size;
    logic [63:0] m_addr, m_wdata;

    logic [63:0] rr_rdata, fx_rdata;
    logic [1:0]  rr_aok, rr_dok, fx_aok, fx_dok;
    logic        rr_en, fx_en;
    logic [3:0]  rr_wen, fx_wen;
    logic [31:0] rr_saddr, rr_swdata, rr_srdata, fx_saddr, fx_swdata, fx_srdata;
`ifdef BRIDGE_PERF_CNT_EN
    logic [63:0] rr_perf, fx_perf;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        ch;
        logic        vld;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [3:0]  wen;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    logic [1:0] exp_rr_cont [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] exp_fx_cont [6] = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00};

    always #5 clk = ~clk;

    sramlike_arb_bridge #(.N_CH(2), .RD_LAT(2), .MAX_OUT(2), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(rr_rdata),
        .m_addr_ok(rr_aok), .m_data_ok(rr_dok), .sram_en(rr_en), .sram_wen(rr_wen),
        .sram_addr(rr_saddr), .sram_wdata(rr_swdata), .sram_rdata(rr_srdata)
`ifdef BRIDGE_PERF_CNT_EN
        , .perf_stall(rr_perf)
`endif
    );

    sramlike_arb_bridge #(.N_CH(2), .RD_LAT(3), .MAX_OUT(1), .ARB_MODE(1)) u_fx (
        .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(fx_rdata),
        .m_addr_ok(fx_aok), .m_data_ok(fx_dok), .sram_en(fx_en), .sram_wen(fx_wen),
        .sram_addr(fx_saddr), .sram_wdata(fx_swdata), .sram_rdata(fx_srdata)
`ifdef BRIDGE_PERF_CNT_EN
        , .perf_stall(fx_perf)
`endif
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h0000_0104) ? 32'hDEAD_BEEF : ((a ^ 32'hC0DE_0000) + 32'd1);
    endfunction

    // SRAM models: address captured on the enable edge, data presented RD_LAT cycles after sram_en.
    logic [31:0] ap_rr [2];
    logic [31:0] ap_fx [3];
    always @(posedge clk) begin
        ap_rr[0] <= rr_saddr;
        ap_rr[1] <= ap_rr[0];
        ap_fx[0] <= fx_saddr;
        ap_fx[1] <= ap_fx[0];
        ap_fx[2] <= ap_fx[1];
    end
    assign rr_srdata = mem_val(ap_rr[1]);
    assign fx_srdata = mem_val(ap_fx[2]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_req   = '0;
        m_wr    = '0;
        m_size  = '0;
        m_addr  = '0;
        m_wdata = '0;
    endtask

    task automatic drive(input int ch, input logic wr, input logic [1:0] sz, input logic [31:0] a);
        m_req[ch]            = 1'b1;
        m_wr[ch]             = wr;
        m_size[ch*2 +: 2]    = sz;
        m_addr[ch*32 +: 32]  = a;
        m_wdata[ch*32 +: 32] = a ^ 32'h1111_1111;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_ctl"}, 32'({rr_aok, rr_dok, rr_en, rr_wen, fx_aok, fx_dok, fx_en, fx_wen}), 32'd0);
        chk({name, "_rdata"}, rr_rdata[31:0] | rr_rdata[63:32] | fx_rdata[31:0] | fx_rdata[63:32], 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1);
    end

    initial begin
        int         oc;
        int         bad;
        logic [1:0] exp_ok;
        logic [31:0] lane;

        vt[0]  = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_0104, 4'b0000};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_2003, 4'b1000};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_2002, 4'b1100};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_3001, 4'b0000};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 2'd2, 32'h0000_3000, 4'b1111};
        vt[5]  = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h0000_3002, 4'b0000};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 2'd3, 32'h0000_4000, 4'b1111};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_4001, 4'b0010};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_4000, 4'b0011};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_5003, 4'b0000};
        vt[10] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_6002, 4'b0000};
        vt[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_0000, 4'b0000};

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        tick();
        rst = 1'b0;

        // Reset while a read is in flight: it must never be answered.
        tick();
        drive(0, 1'b0, 2'd2, 32'h0000_1000);
        @(negedge clk);
        chk("mf_aok_rr", 32'(rr_aok), 32'h1);
        chk("mf_aok_fx", 32'(fx_aok), 32'h1);
        tick();
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("mf_in_reset");
        tick();
        tick();
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if ((rr_dok | fx_dok) != 2'b00) bad++;
            tick();
        end
        chk("mf_no_dok", 32'(bad), 32'd0);
        drive(0, 1'b0, 2'd2, 32'h0000_1004);
        @(negedge clk);
        chk("mf_cnt_clear_fx", 32'(fx_aok), 32'h1);
        tick();
        idle();
        repeat (4) tick();

        // Table: one access per vector, then check handshake, enables, latency and returned data.
        for (int v = 0; v < NV; v++) begin
            idle();
            oc = vt[v].ch ? 0 : 1;
            if (vt[v].vld) begin
                m_wr[oc]             = ~vt[v].wr;
                m_size[oc*2 +: 2]    = 2'd2;
                m_addr[oc*32 +: 32]  = 32'hFFFF_FFF0;
                m_wdata[oc*32 +: 32] = 32'h5555_5555;
                drive(int'(vt[v].ch), vt[v].wr, vt[v].sz, vt[v].addr);
            end
            exp_ok = vt[v].vld ? (vt[v].ch ? 2'b10 : 2'b01) : 2'b00;
            @(negedge clk);
            chk($sformatf("vec%0d_aok", v), 32'(rr_aok), 32'(exp_ok));
            chk($sformatf("vec%0d_en", v), 32'(rr_en), 32'(vt[v].vld));
            chk($sformatf("vec%0d_wen", v), 32'(rr_wen), 32'(vt[v].wen));
            if (vt[v].vld) begin
                chk($sformatf("vec%0d_addr", v), rr_saddr, vt[v].addr);
                chk($sformatf("vec%0d_wdata", v), rr_swdata, vt[v].addr ^ 32'h1111_1111);
            end
            tick();
            idle();
            @(negedge clk);
            chk($sformatf("vec%0d_dok_early", v), 32'(rr_dok), 32'd0);
            tick();
            @(negedge clk);
            chk($sformatf("vec%0d_dok", v), 32'(rr_dok), 32'(exp_ok));
            lane = vt[v].ch ? rr_rdata[63:32] : rr_rdata[31:0];
            if (vt[v].vld && !vt[v].wr) chk($sformatf("vec%0d_rdata", v), lane, mem_val(vt[v].addr));
            tick();
            @(negedge clk);
            chk($sformatf("vec%0d_dok_pulse", v), 32'(rr_dok), 32'd0);
            tick();
        end

        // Both channels requesting: RR alternates; fixed priority favours ch1 within MAX_OUT.
        do_reset();
        drive(0, 1'b0, 2'd2, 32'h0000_0200);
        drive(1, 1'b0, 2'd2, 32'h0000_0300);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("cont%0d_rr", c), 32'(rr_aok), 32'(exp_rr_cont[c]));
            chk($sformatf("cont%0d_fx", c), 32'(fx_aok), 32'(exp_fx_cont[c]));
            tick();
        end
        idle();
        repeat (4) tick();

        // Outstanding limit: MAX_OUT 1 with RD_LAT 3 accepts every third cycle.
        do_reset();
        drive(0, 1'b0, 2'd2, 32'h0000_0400);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk($sformatf("lim%0d_fx", c), 32'(fx_aok), (c % 3 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("lim%0d_rr", c), 32'(rr_aok), 32'h1);
            tick();
        end
        idle();
        @(negedge clk);
`ifdef BRIDGE_PERF_CNT_EN
        chk("perf_fx_ch0", fx_perf[31:0], 32'd6);
        chk("perf_rr_ch0", rr_perf[31:0], 32'd0);
`endif
        tick();
        repeat (4) tick();

        // In-order return across lanes, with lane 0 data held afterwards.
        do_reset();
        drive(0, 1'b0, 2'd2, 32'h0000_0200);
        @(negedge clk);
        chk("ord_aok0", 32'(rr_aok), 32'h1);
        tick();
        idle();
        drive(1, 1'b0, 2'd2, 32'h0000_0300);
        @(negedge clk);
        chk("ord_aok1", 32'(rr_aok), 32'h2);
        tick();
        idle();
        @(negedge clk);
        chk("ord_dok0", 32'(rr_dok), 32'h1);
        chk("ord_rdata0", rr_rdata[31:0], mem_val(32'h0000_0200));
        tick();
        @(negedge clk);
        chk("ord_dok1", 32'(rr_dok), 32'h2);
        chk("ord_rdata1", rr_rdata[63:32], mem_val(32'h0000_0300));
        chk("ord_hold0", rr_rdata[31:0], mem_val(32'h0000_0200));
        tick();
        @(negedge clk);
        chk("ord_dok_end", 32'(rr_dok), 32'h0);
        chk("ord_hold0_end", rr_rdata[31:0], mem_val(32'h0000_0200));
        chk("ord_hold1_end", rr_rdata[63:32], mem_val(32'h0000_0300));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
